// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage feeding the register-file write port.
//
// ALU results are written back the cycle after acceptance. Loads park the
// stage in WAIT_LOAD until the data memory answers. The returned word is then
// aligned and sign/zero-extended before it is written back. Upstream is held
// off through o_ready while a load is outstanding.
//
// Optional build macro: WB_RETIRE_COUNT_EN adds a 64-bit retire counter
// output (o_retire_count). The block is complete without it.
//
// The write-enable polarity seen by the register file comes from the
// REG_WRITE_EN macro. When the surrounding build does not define it, it
// defaults to active-high.

`ifndef REG_WRITE_EN
`define REG_WRITE_EN 1'b1
`endif

module mem_wb_stage #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  // upstream instruction
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_reg_we,
  input  logic            i_is_load,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_flush,
  // data-memory response
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  // register-file write port
  output logic [4:0]      o_writereg,
  output logic [XLEN-1:0] o_writedata,
  output logic            o_readwrite,
  output logic            o_fault
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]     o_retire_count
`endif
);

  // Register-file enable levels, resolved once from the polarity macro.
  localparam logic WE_ON  = `REG_WRITE_EN;
  localparam logic WE_OFF = ~WE_ON;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t state;

  // Fields of the outstanding load. They are captured at acceptance because
  // upstream moves on as soon as the stage is ready again.
  logic [4:0] cap_rd;
  logic [2:0] cap_funct3;
  logic [1:0] cap_off;

  // Aligned load result and its fault flag. They are only meaningful in
  // WAIT_LOAD while i_mem_rvalid is high.
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic            load_fault;

  // The stage accepts only when no load is pending.
  assign o_ready = (state == IDLE);

  // Pick the addressed byte/halfword out of the returned word, extend it, and
  // flag misaligned or unsupported load encodings.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    load_data  = '0;
    load_fault = 1'b0;
    load_byte  = 8'(i_mem_rdata >> {cap_off, 3'b000});
    load_half  = 16'(i_mem_rdata >> {cap_off[1], 4'b0000});
    case (cap_funct3)
      F3_LB:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LBU: load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LH: begin
        load_fault = cap_off[0];
        load_data  = {{(XLEN-16){load_half[15]}}, load_half};
      end
      F3_LHU: begin
        load_fault = cap_off[0];
        load_data  = {{(XLEN-16){1'b0}}, load_half};
      end
      F3_LW: begin
        load_fault = (cap_off != 2'b00);
        load_data  = i_mem_rdata;
      end
      default: load_fault = 1'b1;  // 011, 110, 111 are not loads we support
    endcase
  end

  // Control FSM with registered write-port outputs. Write and fault are
  // single-cycle pulses. A flush squashes everything due for the next cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      o_writereg  <= '0;
      o_writedata <= '0;
      o_readwrite <= WE_OFF;
      o_fault     <= 1'b0;
      cap_rd      <= '0;
      cap_funct3  <= '0;
      cap_off     <= '0;
    end else begin
      // NOTE: state lives in always_ff and uses non-blocking assignments, so
      // every register samples pre-edge values regardless of statement order.
      o_readwrite <= WE_OFF;
      o_fault     <= 1'b0;

      if (i_flush) begin
        // Drops a same-cycle accept or memory response. A response that
        // arrives later is ignored because the stage is back in IDLE.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              if (i_is_load) begin
                cap_rd     <= i_rd;
                cap_funct3 <= i_funct3;
                cap_off    <= i_alu_result[1:0];
                state      <= WAIT_LOAD;
              end else begin
                o_writereg  <= i_rd;
                o_writedata <= i_alu_result;
                if (i_reg_we && (i_rd != 5'd0)) begin
                  o_readwrite <= WE_ON;
                end
              end
            end
          end

          WAIT_LOAD: begin
            if (i_mem_rvalid) begin
              state <= IDLE;
              if (load_fault) begin
                o_fault <= 1'b1;
              end else begin
                o_writereg  <= cap_rd;
                o_writedata <= load_data;
                if (cap_rd != 5'd0) begin
                  o_readwrite <= WE_ON;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  // An instruction retires on the edge that presents its write or fault
  // pulse. A non-load that does not write also retires when it completes.
  // Flushed work never retires.
  logic retire_now;

  // Decide whether the coming edge retires an instruction.
  always_comb begin
    retire_now = 1'b0;
    if (!i_flush) begin
      if (state == IDLE) begin
        retire_now = i_valid && !i_is_load;
      end else begin
        retire_now = i_mem_rvalid && (load_fault || (cap_rd != 5'd0));
      end
    end
  end

  // Free-running retire count. It wraps naturally at 2^64.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_retire_count <= '0;
    end else if (retire_now) begin
      o_retire_count <= o_retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized bench for mem_wb_stage.
// Load results come from an arithmetic model of the load rules, not from
// the design's datapath.

`timescale 1ns/1ps

`ifndef REG_WRITE_EN
`define REG_WRITE_EN 1'b1
`endif

module tb_mem_wb_stage;

  localparam logic WE_ON  = `REG_WRITE_EN;
  localparam logic WE_OFF = ~WE_ON;

  logic        i_clock;
  logic        i_reset_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_reg_we;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic [31:0] i_alu_result;
  logic        i_flush;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [4:0]  o_writereg;
  logic [31:0] o_writedata;
  logic        o_readwrite;
  logic        o_fault;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] o_retire_count;
`endif

  int vectors;
  int miscompares;
  int exp_retire;

  mem_wb_stage #(.XLEN(32)) dut (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_reg_we     (i_reg_we),
    .i_is_load    (i_is_load),
    .i_funct3     (i_funct3),
    .i_rd         (i_rd),
    .i_alu_result (i_alu_result),
    .i_flush      (i_flush),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_writereg   (o_writereg),
    .o_writedata  (o_writedata),
    .o_readwrite  (o_readwrite),
    .o_fault      (o_fault)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .o_retire_count (o_retire_count)
`endif
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge. Outputs are settled there,
  // and new inputs are stable well before the following edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, o_readwrite, WE_OFF);
    check({tag, "_fault"}, o_fault, 1'b0);
  endtask

  // Reference load model. It uses plain arithmetic on the byte lanes.
  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] off,
                                   input logic [31:0] word, output logic fault,
                                   output logic [31:0] data);
    longint unsigned w = word;
    int unsigned     o = off;
    longint unsigned b = (w / (longint'(256) ** o)) % 256;
    longint unsigned h = (w / (longint'(65536) ** (o / 2))) % 65536;
    fault = 1'b0;
    data  = '0;
    case (f3)
      3'd0: data = (b >= 128) ? 32'(longint'(b) - 256) : 32'(b);
      3'd4: data = 32'(b);
      3'd1: begin
        fault = (o % 2) != 0;
        data  = (h >= 32768) ? 32'(longint'(h) - 65536) : 32'(h);
      end
      3'd5: begin
        fault = (o % 2) != 0;
        data  = 32'(h);
      end
      3'd2: begin
        fault = (o != 0);
        data  = word;
      end
      default: fault = 1'b1;
    endcase
  endfunction

  task automatic issue_alu(input logic [4:0] rd, input logic we,
                           input logic [31:0] val, input logic flush);
    i_valid      = 1'b1;
    i_is_load    = 1'b0;
    i_reg_we     = we;
    i_rd         = rd;
    i_alu_result = val;
    i_funct3     = 3'($urandom_range(0, 7));
    i_flush      = flush;
    check("alu_ready", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    if (!flush && we && rd != 5'd0) begin
      check("alu_we", o_readwrite, WE_ON);
      check("alu_reg", o_writereg, rd);
      check("alu_data", o_writedata, val);
    end else begin
      check("alu_nowrite", o_readwrite, WE_OFF);
    end
    check("alu_fault", o_fault, 1'b0);
    check("alu_ready_after", o_ready, 1'b1);
    if (!flush) exp_retire++;
    tick();
    check_quiet("alu_pulse_end");
  endtask

  // Issue a load and return the memory response after 'delay' cycles (>=1).
  // When 'flush' is set, the flush coincides with the response.
  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input int delay, input logic flush);
    logic        m_fault;
    logic [31:0] m_data;
    i_valid      = 1'b1;
    i_is_load    = 1'b1;
    i_reg_we     = 1'b1;
    i_rd         = rd;
    i_funct3     = f3;
    i_alu_result = addr;
    check("ld_ready", o_ready, 1'b1);
    tick();
    i_valid      = 1'b0;
    i_is_load    = 1'b0;
    i_rd         = 5'($urandom);
    i_funct3     = 3'($urandom);
    i_alu_result = $urandom;
    i_mem_rdata  = $urandom;
    for (int k = 0; k < delay; k++) begin
      check("ld_wait_ready", o_ready, 1'b0);
      check_quiet("ld_wait");
      if (k == delay - 1) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rdata;
        i_flush      = flush;
      end
      tick();
    end
    i_mem_rvalid = 1'b0;
    i_flush      = 1'b0;
    ref_load(f3, addr[1:0], rdata, m_fault, m_data);
    check("ld_done_ready", o_ready, 1'b1);
    if (flush) begin
      check_quiet("ld_flushed");
    end else if (m_fault) begin
      check("ld_fault", o_fault, 1'b1);
      check("ld_fault_nowrite", o_readwrite, WE_OFF);
      exp_retire++;
    end else begin
      check("ld_nofault", o_fault, 1'b0);
      if (rd != 5'd0) begin
        check("ld_we", o_readwrite, WE_ON);
        check("ld_reg", o_writereg, rd);
        check("ld_data", o_writedata, m_data);
        exp_retire++;
      end else begin
        check("ld_rd0_nowrite", o_readwrite, WE_OFF);
      end
    end
    tick();
    check_quiet("ld_pulse_end");
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    #1;
    check("rst_reg", o_writereg, 5'd0);
    check("rst_data", o_writedata, 32'd0);
    check("rst_we", o_readwrite, WE_OFF);
    check("rst_fault", o_fault, 1'b0);
    check("rst_ready", o_ready, 1'b1);
`ifdef WB_RETIRE_COUNT_EN
    check("rst_retire", o_retire_count, 64'd0);
`endif
    exp_retire = 0;
    #7;
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    exp_retire   = 0;
    i_reset_n    = 1'b1;
    i_valid      = 1'b0;
    i_reg_we     = 1'b0;
    i_is_load    = 1'b0;
    i_funct3     = 3'd0;
    i_rd         = 5'd0;
    i_alu_result = 32'd0;
    i_flush      = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    #2;
    apply_reset();

    // Reset while a load is pending, then an ALU op to rd=5.
    issue_alu(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0);
    i_valid = 1'b1; i_is_load = 1'b1; i_rd = 5'd3; i_funct3 = 3'd2;
    i_alu_result = 32'h100;
    tick();
    i_valid = 1'b0; i_is_load = 1'b0;
    check("pre_rst_wait", o_ready, 1'b0);
    #2;
    apply_reset();
    issue_alu(5'd5, 1'b1, 32'h0000_1234, 1'b0);

    // Byte loads at offset 3, signed and unsigned.
    issue_load(5'd6, 3'b000, 32'h0000_2003, 32'h80FF_FF7F, 1, 1'b0);
    issue_load(5'd6, 3'b100, 32'h0000_2003, 32'h80FF_FF7F, 2, 1'b0);
    // Halfword at offset 2, then a misaligned word.
    issue_load(5'd7, 3'b001, 32'h0000_3002, 32'h8001_0000, 1, 1'b0);
    issue_load(5'd7, 3'b010, 32'h0000_3001, 32'h1234_5678, 1, 1'b0);
    // Misaligned halfword, unsupported encoding, faulting load to rd=0.
    issue_load(5'd8, 3'b101, 32'h0000_0001, 32'hAAAA_5555, 1, 1'b0);
    issue_load(5'd8, 3'b110, 32'h0000_0000, 32'hAAAA_5555, 1, 1'b0);
    issue_load(5'd0, 3'b111, 32'h0000_0000, 32'hAAAA_5555, 1, 1'b0);

    // Response four cycles after acceptance while the next op waits upstream.
    i_valid = 1'b1; i_is_load = 1'b1; i_reg_we = 1'b1; i_rd = 5'd10;
    i_funct3 = 3'b010; i_alu_result = 32'h0000_4000;
    tick();
    i_is_load = 1'b0; i_rd = 5'd11; i_alu_result = 32'h0000_ABCD;
    for (int k = 0; k < 4; k++) begin
      check("hold_ready", o_ready, 1'b0);
      check_quiet("hold");
      if (k == 3) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hCAFE_F00D;
      end
      tick();
    end
    i_mem_rvalid = 1'b0;
    check("hold_wb_we", o_readwrite, WE_ON);
    check("hold_wb_reg", o_writereg, 5'd10);
    check("hold_wb_data", o_writedata, 32'hCAFE_F00D);
    check("hold_wb_ready", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    check("next_we", o_readwrite, WE_ON);
    check("next_reg", o_writereg, 5'd11);
    check("next_data", o_writedata, 32'h0000_ABCD);
    tick();
    check_quiet("next_end");
    exp_retire += 2;

    // Back-to-back ALU ops, one write per cycle.
    i_valid = 1'b1; i_is_load = 1'b0; i_reg_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_rd = 5'(12 + k);
      i_alu_result = 32'h1000 + 32'(k);
      tick();
      check("b2b_we", o_readwrite, WE_ON);
      check("b2b_reg", o_writereg, 5'(12 + k));
      check("b2b_data", o_writedata, 32'h1000 + 32'(k));
      exp_retire++;
    end
    i_valid = 1'b0;
    tick();
    check_quiet("b2b_end");

    // Flush coinciding with the response, then a stray response in IDLE.
    issue_load(5'd4, 3'b010, 32'h0000_0010, 32'h5555_AAAA, 2, 1'b0);
    issue_load(5'd4, 3'b010, 32'h0000_0010, 32'h5555_AAAA, 2, 1'b1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFFFF_FFFF;
    tick();
    i_mem_rvalid = 1'b0;
    check_quiet("stray_rvalid");
    check("stray_ready", o_ready, 1'b1);
    // Non-writing ALU ops and a flushed accept.
    issue_alu(5'd0, 1'b1, 32'h0BAD_0BAD, 1'b0);
    issue_alu(5'd3, 1'b0, 32'h0BAD_0BAD, 1'b0);
    issue_alu(5'd3, 1'b1, 32'h0BAD_0BAD, 1'b1);

    // Retire count: 3 ALU ops, 1 faulting load, 1 flushed load.
    apply_reset();
    issue_alu(5'd1, 1'b1, 32'd1, 1'b0);
    issue_alu(5'd2, 1'b1, 32'd2, 1'b0);
    issue_alu(5'd0, 1'b1, 32'd3, 1'b0);
    issue_load(5'd5, 3'b010, 32'h0000_0002, 32'd0, 1, 1'b0);
    issue_load(5'd5, 3'b010, 32'h0000_0000, 32'd0, 2, 1'b1);
`ifdef WB_RETIRE_COUNT_EN
    check("retire_four", o_retire_count, 64'd4);
`endif

    // Randomized mix.
    for (int n = 0; n < 80; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 0) begin
        issue_alu(rd, 1'($urandom), $urandom, ($urandom_range(0, 9) == 0));
      end else begin
        issue_load(rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   int'($urandom_range(1, 4)), ($urandom_range(0, 9) == 0));
      end
    end
`ifdef WB_RETIRE_COUNT_EN
    check("retire_random", o_retire_count, 64'(exp_retire));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
